// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back port arbiter.
// Source-id constants, the default widths and FIFO depth, and the queued entry layout.
package wb_pkg;

    localparam int WB_REG_ADDR_WIDTH = 5;
    localparam int WB_DATA_WIDTH     = 32;
    localparam int WB_FIFO_DEPTH     = 2;

    localparam logic WB_SRC_EXE = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef struct packed {
        logic [WB_REG_ADDR_WIDTH-1:0] rd;
        logic [WB_DATA_WIDTH-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_req_fifo.sv
// Small synchronous request FIFO holding {rd, data} entries for one result source.
// DEPTH must be a power of two (>= 2), so the pointers wrap naturally.
// A push while full or a pop while empty is ignored.
module wb_req_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = WB_REG_ADDR_WIDTH + WB_DATA_WIDTH,
    parameter int DEPTH = WB_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_entry,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign head    = store[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointer, count and storage update; push and pop together keep the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                store[i] <= '0;
            end
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_entry;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: EXE and MEM results queue in their own FIFO and one
// arbiter drains a single head per cycle into the registered register-file write port.
// Handshake: a source transfer happens on a rising edge where x_valid && x_ready;
// x_ready depends only on the FIFO not being full (never on a same-cycle pop).
// Macro WB_RR_ARB_EN: defined -> round-robin between the sources under contention;
// undefined -> fixed priority, MEM over EXE.
// Entries with rd == 0 are consumed without a write strobe.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = WB_REG_ADDR_WIDTH,
    parameter int DATA_WIDTH     = WB_DATA_WIDTH,
    parameter int FIFO_DEPTH     = WB_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      exe_valid,
    output logic                      exe_ready,
    input  logic [REG_ADDR_WIDTH-1:0] exe_rd,
    input  logic [DATA_WIDTH-1:0]     exe_data,
    input  logic                      mem_valid,
    output logic                      mem_ready,
    input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]     mem_data,
    output logic [REG_ADDR_WIDTH-1:0] WrtBck_Addr,
    output logic [DATA_WIDTH-1:0]     WrtBck_Data,
    output logic                      Wr_En,
    output logic                      wb_pending
);

    localparam int EW = REG_ADDR_WIDTH + DATA_WIDTH;

    logic          exe_full, exe_empty, mem_full, mem_empty;
    logic [EW-1:0] exe_head, mem_head, grant_entry;
    logic          grant_any, grant_src, pop_exe, pop_mem;
    logic [REG_ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0]     grant_data;

    wb_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_exe_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (exe_valid),
        .push_entry ({exe_rd, exe_data}),
        .pop        (pop_exe),
        .full       (exe_full),
        .empty      (exe_empty),
        .head       (exe_head)
    );

    wb_req_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (mem_valid),
        .push_entry ({mem_rd, mem_data}),
        .pop        (pop_mem),
        .full       (mem_full),
        .empty      (mem_empty),
        .head       (mem_head)
    );

    assign exe_ready  = !exe_full;
    assign mem_ready  = !mem_full;
    assign wb_pending = !exe_empty || !mem_empty;

`ifdef WB_RR_ARB_EN
    logic rr_ptr;

    // Preferred-source pointer: flips only after a grant made under contention.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= WB_SRC_MEM;
        end else if (!exe_empty && !mem_empty) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // Source selection: the lone non-empty FIFO wins, otherwise the preferred one.
    always_comb begin
        grant_src = WB_SRC_EXE;
        if (!exe_empty && !mem_empty) begin
            grant_src = rr_ptr;
        end else if (!mem_empty) begin
            grant_src = WB_SRC_MEM;
        end
    end
`else
    // Source selection: MEM always wins when it holds an entry.
    always_comb begin
        grant_src = WB_SRC_EXE;
        if (!mem_empty) begin
            grant_src = WB_SRC_MEM;
        end
    end
`endif

    assign grant_any   = !exe_empty || !mem_empty;
    assign pop_exe     = grant_any && (grant_src == WB_SRC_EXE);
    assign pop_mem     = grant_any && (grant_src == WB_SRC_MEM);
    assign grant_entry = (grant_src == WB_SRC_MEM) ? mem_head : exe_head;
    assign grant_rd    = grant_entry[EW-1 -: REG_ADDR_WIDTH];
    assign grant_data  = grant_entry[DATA_WIDTH-1:0];

    // Registered write port; x0 writes and idle cycles keep the last address/data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Wr_En       <= 1'b0;
            WrtBck_Addr <= '0;
            WrtBck_Data <= '0;
        end else if (grant_any && (grant_rd != '0)) begin
            Wr_En       <= 1'b1;
            WrtBck_Addr <= grant_rd;
            WrtBck_Data <= grant_data;
        end else begin
            Wr_En       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: queue-based behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_wb_port_arbiter;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk;
    logic          reset;
    logic          exe_valid, exe_ready, mem_valid, mem_ready;
    logic [AW-1:0] exe_rd, mem_rd, WrtBck_Addr;
    logic [DW-1:0] exe_data, mem_data, WrtBck_Data;
    logic          Wr_En, wb_pending;

    int n_checks = 0;
    int n_err    = 0;
    bit started  = 0;

    wb_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .exe_valid   (exe_valid),
        .exe_ready   (exe_ready),
        .exe_rd      (exe_rd),
        .exe_data    (exe_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .WrtBck_Addr (WrtBck_Addr),
        .WrtBck_Data (WrtBck_Data),
        .Wr_En       (Wr_En),
        .wb_pending  (wb_pending)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // Each source is a plain queue of {rd,data}; the write port holds the last write.
    logic [AW+DW-1:0] exp_exe_q[$];
    logic [AW+DW-1:0] exp_mem_q[$];
    logic             m_wr_en;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_data;
    bit               next_contest_mem;  // who wins the next contested cycle (round-robin)
    logic [AW-1:0]    wr_log[$];

    always @(posedge clk or negedge reset) begin
        logic [AW+DW-1:0] ent;
        bit               take_mem, any, acc_e, acc_m;
        if (!reset) begin
            exp_exe_q.delete();
            exp_mem_q.delete();
            m_wr_en          <= 1'b0;
            m_addr           <= '0;
            m_data           <= '0;
            next_contest_mem <= 1'b1;
        end else begin
            acc_e = exe_valid && (exp_exe_q.size() < DEPTH);
            acc_m = mem_valid && (exp_mem_q.size() < DEPTH);
            any   = (exp_exe_q.size() != 0) || (exp_mem_q.size() != 0);
            if ((exp_exe_q.size() != 0) && (exp_mem_q.size() != 0)) begin
`ifdef WB_RR_ARB_EN
                take_mem = next_contest_mem;
                next_contest_mem <= !next_contest_mem;
`else
                take_mem = 1'b1;
`endif
            end else begin
                take_mem = (exp_mem_q.size() != 0);
            end
            if (any) begin
                ent = take_mem ? exp_mem_q.pop_front() : exp_exe_q.pop_front();
                if (ent[AW+DW-1:DW] != '0) begin
                    m_wr_en <= 1'b1;
                    m_addr  <= ent[AW+DW-1:DW];
                    m_data  <= ent[DW-1:0];
                end else begin
                    m_wr_en <= 1'b0;
                end
            end else begin
                m_wr_en <= 1'b0;
            end
            if (acc_e) exp_exe_q.push_back({exe_rd, exe_data});
            if (acc_m) exp_mem_q.push_back({mem_rd, mem_data});
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard compare (opposite edge) ----------------
    always @(negedge clk) begin
        if (started) begin
            check("wr_en",      64'(Wr_En),       64'(m_wr_en));
            check("addr",       64'(WrtBck_Addr), 64'(m_addr));
            check("data",       64'(WrtBck_Data), 64'(m_data));
            check("wb_pending", 64'(wb_pending),  64'((exp_exe_q.size() != 0) || (exp_mem_q.size() != 0)));
            check("exe_ready",  64'(exe_ready),   64'(exp_exe_q.size() < DEPTH));
            check("mem_ready",  64'(mem_ready),   64'(exp_mem_q.size() < DEPTH));
            if (Wr_En === 1'b1) wr_log.push_back(WrtBck_Addr);
        end
    end

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the falling edge and are consumed at the next rising edge.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        exe_valid = 1'b0;
        mem_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic contend(input int n);
        logic [AW-1:0] e_rd, m_rd;
        bit acc_e, acc_m;
        e_rd = 5'd1;
        m_rd = 5'd9;
        for (int i = 0; i < n; i++) begin
            exe_valid = 1'b1; exe_rd = e_rd; exe_data = {27'h0, e_rd} + 32'h100;
            mem_valid = 1'b1; mem_rd = m_rd; mem_data = {27'h0, m_rd} + 32'h200;
            acc_e = exe_ready;
            acc_m = mem_ready;
            step();
            if (acc_e) e_rd++;
            if (acc_m) m_rd++;
            if (i == 2) begin
`ifdef WB_RR_ARB_EN
                check("full_mem_ready", 64'(mem_ready), 64'd0);
                check("full_exe_ready", 64'(exe_ready), 64'd1);
`else
                check("full_mem_ready", 64'(mem_ready), 64'd1);
                check("full_exe_ready", 64'(exe_ready), 64'd0);
`endif
            end
        end
        exe_valid = 1'b0;
        mem_valid = 1'b0;
    endtask

    task automatic random_traffic(input int n);
        bit acc_e, acc_m;
        for (int i = 0; i < n; i++) begin
            acc_e = exe_valid && exe_ready;
            acc_m = mem_valid && mem_ready;
            if (!exe_valid || acc_e) begin
                exe_valid = ($urandom_range(0, 99) < 60);
                exe_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                exe_data  = $urandom;
            end
            if (!mem_valid || acc_m) begin
                mem_valid = ($urandom_range(0, 99) < 55);
                mem_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                mem_data  = $urandom;
            end
            if ((i % 400) == 399) begin
                reset = 1'b0;
                step();
                reset = 1'b1;
                exe_valid = 1'b0;
                mem_valid = 1'b0;
            end else begin
                step();
            end
        end
        idle(6);
    endtask

    // ---------------- stimulus and literal expectations ----------------
    initial begin
        reset = 1'b0;
        exe_valid = 1'b0; exe_rd = '0; exe_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        repeat (3) step();
        reset = 1'b1;
        started = 1'b1;
        step();
        check("rst_wr_en", 64'(Wr_En), 64'd0);
        check("rst_addr",  64'(WrtBck_Addr), 64'd0);
        check("rst_data",  64'(WrtBck_Data), 64'd0);

        // Reset mid-stream: queued EXE writes are discarded.
        exe_valid = 1'b1; exe_rd = 5'd3; exe_data = 32'h11;
        step();
        exe_rd = 5'd4; exe_data = 32'h22;
        step();
        exe_valid = 1'b0;
        wr_log.delete();
        reset = 1'b0;
        #1;
        check("midrst_wr_en",   64'(Wr_En), 64'd0);
        check("midrst_addr",    64'(WrtBck_Addr), 64'd0);
        check("midrst_data",    64'(WrtBck_Data), 64'd0);
        check("midrst_ready",   64'(exe_ready), 64'd1);
        check("midrst_pending", 64'(wb_pending), 64'd0);
        step();
        reset = 1'b1;
        idle(4);
        check("midrst_no_write", 64'(wr_log.size()), 64'd0);

        // Single write through an empty block.
        exe_valid = 1'b1; exe_rd = 5'd5; exe_data = 32'hDEADBEEF;
        step();
        exe_valid = 1'b0;
        check("single_pending", 64'(wb_pending), 64'd1);
        check("single_wait",    64'(Wr_En), 64'd0);
        step();
        check("single_wr_en", 64'(Wr_En), 64'd1);
        check("single_addr",  64'(WrtBck_Addr), 64'd5);
        check("single_data",  64'(WrtBck_Data), 64'hDEADBEEF);
        step();
        check("single_off",       64'(Wr_En), 64'd0);
        check("single_hold_addr", 64'(WrtBck_Addr), 64'd5);
        check("single_hold_data", 64'(WrtBck_Data), 64'hDEADBEEF);

        // x0 drop followed by a real write.
        exe_valid = 1'b1; exe_rd = 5'd0; exe_data = 32'hFFFF;
        step();
        exe_rd = 5'd7; exe_data = 32'h1;
        step();
        exe_valid = 1'b0;
        check("x0_wr_en", 64'(Wr_En), 64'd0);
        check("x0_addr",  64'(WrtBck_Addr), 64'd5);
        check("x0_data",  64'(WrtBck_Data), 64'hDEADBEEF);
        step();
        check("x0_next_wr_en", 64'(Wr_En), 64'd1);
        check("x0_next_addr",  64'(WrtBck_Addr), 64'd7);
        check("x0_next_data",  64'(WrtBck_Data), 64'h1);
        idle(2);

        // Same-cycle MEM/EXE arrival.
        wr_log.delete();
        mem_valid = 1'b1; mem_rd = 5'd9; mem_data = 32'h9;
        exe_valid = 1'b1; exe_rd = 5'd1; exe_data = 32'h1;
        step();
        exe_valid = 1'b0;
        mem_rd = 5'd10; mem_data = 32'hA;
        step();
        idle(5);
        check("order_count", 64'(wr_log.size()), 64'd3);
        if (wr_log.size() == 3) begin
`ifdef WB_RR_ARB_EN
            check("order_0", 64'(wr_log[0]), 64'd9);
            check("order_1", 64'(wr_log[1]), 64'd1);
            check("order_2", 64'(wr_log[2]), 64'd10);
`else
            check("order_0", 64'(wr_log[0]), 64'd9);
            check("order_1", 64'(wr_log[1]), 64'd10);
            check("order_2", 64'(wr_log[2]), 64'd1);
`endif
        end

        // Sustained contention with backpressure.
        wr_log.delete();
        contend(12);
        idle(12);
        check("contend_pending", 64'(wb_pending), 64'd0);
        check("contend_count", 64'(wr_log.size() >= 4), 64'd1);
        if (wr_log.size() >= 4) begin
`ifdef WB_RR_ARB_EN
            check("contend_0", 64'(wr_log[0]), 64'd9);
            check("contend_1", 64'(wr_log[1]), 64'd1);
            check("contend_2", 64'(wr_log[2]), 64'd10);
            check("contend_3", 64'(wr_log[3]), 64'd2);
`else
            check("contend_0", 64'(wr_log[0]), 64'd9);
            check("contend_1", 64'(wr_log[1]), 64'd10);
            check("contend_2", 64'(wr_log[2]), 64'd11);
            check("contend_3", 64'(wr_log[3]), 64'd12);
`endif
        end

        // Randomized traffic with occasional resets.
        random_traffic(2400);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
